// File: rtl/ct_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ct_reader_pkg
// Brief    : Shared types and constants for the ciphertext RAM read-back path.
//            CT_READER_CHECKSUM_EN adds one XOR checksum byte per word.
// Revision : 1.0 - initial release
// ============================================================================
package ct_reader_pkg;

    // Read-back controller states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int WORD_W         = 128;
    localparam int BYTES_PER_WORD = 16;

`ifdef CT_READER_CHECKSUM_EN
    // Sixteen data bytes followed by one checksum byte
    localparam int BYTES_OUT = BYTES_PER_WORD + 1;
`else
    localparam int BYTES_OUT = BYTES_PER_WORD;
`endif

    // Byte counter must reach BYTES_OUT (checksum slot index when enabled)
    localparam int CNT_W = $clog2(BYTES_OUT + 1);

endpackage
`default_nettype wire

// File: rtl/ct_byte_shifter.sv
`default_nettype none
// ============================================================================
// Module   : ct_byte_shifter
// Brief    : 128-bit parallel-load, byte-serial (MSB first) shift register
//            with a byte counter. With CT_READER_CHECKSUM_EN defined it also
//            accumulates the XOR of the shifted-out bytes and presents it as
//            the byte following the sixteenth data byte.
// Revision : 1.0 - initial release
// ============================================================================
module ct_byte_shifter
    import ct_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_din,
    input  logic              i_advance,
    output logic [7:0]        o_byte,
    output logic [CNT_W-1:0]  o_byte_cnt
);

    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;

    // Load a fresh word, or move the next byte into the top slot on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_din;
            r_cnt   <= '0;
        end else if (i_advance) begin
            r_shift <= {r_shift[WORD_W-9:0], 8'h00};
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_byte_cnt = r_cnt;

`ifdef CT_READER_CHECKSUM_EN
    localparam logic [CNT_W-1:0] c_csum_idx = CNT_W'(BYTES_PER_WORD);

    logic [7:0] r_csum;

    // Running XOR of every byte that has left the top slot of this word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum <= '0;
        end else if (i_load) begin
            r_csum <= '0;
        end else if (i_advance) begin
            r_csum <= r_csum ^ r_shift[WORD_W-1 -: 8];
        end
    end

    // Once all data bytes are gone, the checksum takes the output slot
    assign o_byte = (r_cnt == c_csum_idx) ? r_csum : r_shift[WORD_W-1 -: 8];
`else
    assign o_byte = r_shift[WORD_W-1 -: 8];
`endif

endmodule
`default_nettype wire

// File: rtl/ct_ram_reader.sv
`default_nettype none
// ============================================================================
// Module   : ct_ram_reader
// Brief    : Reads NUM_WORDS 128-bit ciphertext words from a single-port RAM
//            starting at address 0 and streams them out as bytes, MSB first,
//            over a valid/ready interface. A one-cycle start pulse begins the
//            read-back; done pulses after the final byte is accepted.
//            Optional feature macro: CT_READER_CHECKSUM_EN (per-word XOR byte).
// Revision : 1.0 - initial release
// ============================================================================
module ct_ram_reader
    import ct_reader_pkg::*;
#(
    parameter int NUM_WORDS = 1,
    parameter int ADDR_W    = 1,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    input  logic [WORD_W-1:0] ram_q,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last
);

    // Elaboration-time parameter sanity
    if ((2 ** ADDR_W) < NUM_WORDS) begin : g_bad_addr_w
        $error("ct_ram_reader: ADDR_W cannot address NUM_WORDS words");
    end
    if ((RD_LAT < 1) || (RD_LAT > 2)) begin : g_bad_rd_lat
        $error("ct_ram_reader: RD_LAT must be 1 or 2");
    end

    localparam logic [1:0]        c_lat_last  = 2'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0]  c_last_byte = CNT_W'(BYTES_OUT - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [1:0]        r_lat;
    logic              r_busy;
    logic              r_done;
    logic              r_rden;
    logic [ADDR_W-1:0] r_addr;
    logic              r_tx_valid;
    logic              r_tx_last;

    logic              w_hs;
    logic              w_load;
    logic              w_last_word;
    logic [7:0]        w_byte;
    logic [CNT_W-1:0]  w_cnt;

    assign w_hs        = r_tx_valid & tx_ready;
    assign w_load      = (r_state == S_WAIT) && (r_lat == c_lat_last);
    assign w_last_word = (r_idx == c_last_idx);

    ct_byte_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_din      (ram_q),
        .i_advance  (w_hs),
        .o_byte     (w_byte),
        .o_byte_cnt (w_cnt)
    );

    // Read-back sequencer: fetch a word, wait out RAM latency, drain its bytes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_lat      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rden     <= 1'b0;
            r_addr     <= '0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_READ;
                        r_idx   <= '0;
                        r_addr  <= '0;
                        r_rden  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    r_rden  <= 1'b0;
                    r_lat   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_lat == c_lat_last) begin
                        r_state    <= S_SEND;
                        r_tx_valid <= 1'b1;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (w_cnt == c_last_byte) begin
                            r_tx_valid <= 1'b0;
                            r_tx_last  <= 1'b0;
                            if (w_last_word) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_idx   <= r_idx + 1'b1;
                                r_addr  <= r_idx + 1'b1;
                                r_rden  <= 1'b1;
                                r_state <= S_READ;
                            end
                        end else begin
                            // Flag the next byte if it closes the whole read-back
                            r_tx_last <= w_last_word && ((w_cnt + 1'b1) == c_last_byte);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign ram_addr = r_addr;
    assign ram_rden = r_rden;
    assign tx_data  = w_byte;
    assign tx_valid = r_tx_valid;
    assign tx_last  = r_tx_last;

endmodule
`default_nettype wire

// File: tb/tb_ct_ram_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_ram_reader
// Brief    : Self-checking bench for ct_ram_reader (two words, RD_LAT = 2).
//            Expected byte streams come from a queue-based model of the
//            stored words; honours CT_READER_CHECKSUM_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ct_ram_reader;

    localparam int NUM_WORDS = 2;
    localparam int ADDR_W    = 1;
    localparam int RD_LAT    = 2;
    localparam int BPW       = 16;
`ifdef CT_READER_CHECKSUM_EN
    localparam int BOUT = BPW + 1;
`else
    localparam int BOUT = BPW;
`endif
    // Ready-high timing: first byte at 2+RD_LAT, word stride BOUT+1+RD_LAT
    localparam int FIRST_VALID = 2 + RD_LAT;
    localparam int DONE_CYC    = FIRST_VALID + (NUM_WORDS - 1) * (BOUT + 1 + RD_LAT) + BOUT;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rden;
    logic [127:0]      ram_q;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;

    int n_checks = 0;
    int n_fail   = 0;

    ct_ram_reader #(
        .NUM_WORDS (NUM_WORDS),
        .ADDR_W    (ADDR_W),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .ram_addr (ram_addr),
        .ram_rden (ram_rden),
        .ram_q    (ram_q),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last)
    );

    always #5 clk = ~clk;

    // RAM model: q valid RD_LAT cycles after rden; garbage when not read
    logic [127:0] mem [0:(1<<ADDR_W)-1];
    logic [127:0] p1, p2;
    always @(posedge clk) begin
        p1 <= ram_rden ? mem[ram_addr] : {$urandom, $urandom, $urandom, $urandom};
        p2 <= p1;
    end
    assign ram_q = (RD_LAT == 1) ? p1 : p2;

    // Reference stream and observations
    logic [7:0] exp_d[$];
    logic       exp_l[$];
    logic [7:0] obs_d[$];
    logic       obs_l[$];
    int         obs_addr[$];
    int         hold_err, first_valid, done_cyc, done_count;
    logic       busy1, rden1, busy_after;

    task automatic build_model();
        logic [7:0] x, b;
        exp_d.delete();
        exp_l.delete();
        for (int w = 0; w < NUM_WORDS; w++) begin
            x = 8'h00;
            for (int i = 0; i < BPW; i++) begin
                b = mem[w][127 - 8*i -: 8];
                x = x ^ b;
                exp_d.push_back(b);
                exp_l.push_back(1'b0);
            end
`ifdef CT_READER_CHECKSUM_EN
            exp_d.push_back(x);
            exp_l.push_back(1'b0);
`endif
        end
        exp_l[exp_l.size()-1] = 1'b1;
    endtask

    // Drives one read-back and records what the DUT emits (no checking here).
    // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic collect(input int mode, input int restart_k, input int abort_after);
        int   hs;
        bit   stall;
        logic [7:0] pd;
        logic pl;
        obs_d.delete(); obs_l.delete(); obs_addr.delete();
        hold_err = 0; first_valid = -1; done_cyc = -1; done_count = 0;
        busy1 = 1'bx; rden1 = 1'bx; busy_after = 1'bx;
        hs = 0; stall = 0; pd = '0; pl = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 600; k++) begin
            start = (k == 0) || (k == restart_k);
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ((k % 3) == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (k == 1) begin busy1 = busy; rden1 = ram_rden; end
            if (ram_rden) obs_addr.push_back(int'(ram_addr));
            if (stall && (!tx_valid || tx_data !== pd || tx_last !== pl)) hold_err++;
            if (tx_valid && first_valid < 0) first_valid = k;
            if (tx_valid && tx_ready) begin
                obs_d.push_back(tx_data);
                obs_l.push_back(tx_last);
                hs++;
                stall = 0;
            end else if (tx_valid) begin
                stall = 1; pd = tx_data; pl = tx_last;
            end else begin
                stall = 0;
            end
            if (done) begin done_count++; if (done_cyc < 0) done_cyc = k; end
            if (done_cyc >= 0 && k == done_cyc + 2) busy_after = busy;
            if (abort_after >= 0 && hs == abort_after) break;
            if (done_cyc >= 0 && k >= done_cyc + 3) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic fill_fixed();
        mem[0] = 128'h00112233445566778899aabbccddeeff;
        mem[1] = 128'h0102030405060708090a0b0c0d0e0f10;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, ram_rden, ram_addr, tx_valid, tx_data, tx_last} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b rden=%b addr=%0d valid=%b data=%02h last=%b, want all 0",
                     busy, done, ram_rden, ram_addr, tx_valid, tx_data, tx_last);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, tx_valid, ram_rden} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b valid=%b rden=%b, want 0 0 0", busy, tx_valid, ram_rden);
        end
    endtask

    task automatic test_ready_high();
        fill_fixed();
        build_model();
        collect(0, -1, -1);
        n_checks++;
        if (obs_d.size() != exp_d.size()) begin
            n_fail++;
            $display("FAIL ready_high_count: got %0d bytes, want %0d", obs_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size(); i++) begin
            n_checks++;
            if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL ready_high_byte[%0d]: got %02h last=%b, want %02h last=%b",
                         i, (i < obs_d.size()) ? obs_d[i] : 8'hxx, (i < obs_l.size()) ? obs_l[i] : 1'bx,
                         exp_d[i], exp_l[i]);
            end
        end
        n_checks++;
        if (obs_addr.size() != 2 || obs_addr[0] != 0 || obs_addr[1] != 1) begin
            n_fail++;
            $display("FAIL ram_addr_seq: got %0d reads (first %0d), want reads of 0 then 1",
                     obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : -1);
        end
        n_checks++;
        if (busy1 !== 1'b1 || rden1 !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency: got busy=%b rden=%b at cycle 1, want 1 1", busy1, rden1);
        end
        n_checks++;
        if (first_valid != FIRST_VALID) begin
            n_fail++;
            $display("FAIL first_valid: got cycle %0d, want %0d", first_valid, FIRST_VALID);
        end
        n_checks++;
        if (done_cyc != DONE_CYC || done_count != 1) begin
            n_fail++;
            $display("FAIL done_timing: got cycle %0d (pulses %0d), want cycle %0d (1 pulse)", done_cyc, done_count, DONE_CYC);
        end
        n_checks++;
        if (busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_done: got %b, want 0", busy_after);
        end
    endtask

    task automatic test_backpressure(input int mode, input int iters);
        for (int it = 0; it < iters; it++) begin
            if (mode == 1) fill_fixed();
            else for (int w = 0; w < NUM_WORDS; w++) mem[w] = {$urandom, $urandom, $urandom, $urandom};
            build_model();
            collect(mode, -1, -1);
            n_checks++;
            if (obs_d.size() != exp_d.size() || done_count != 1) begin
                n_fail++;
                $display("FAIL bp%0d_count: got %0d bytes %0d done, want %0d bytes 1 done",
                         mode, obs_d.size(), done_count, exp_d.size());
            end
            for (int i = 0; i < exp_d.size(); i++) begin
                n_checks++;
                if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                    n_fail++;
                    $display("FAIL bp%0d_byte[%0d]: got %02h last=%b, want %02h last=%b", mode,
                             i, (i < obs_d.size()) ? obs_d[i] : 8'hxx, (i < obs_l.size()) ? obs_l[i] : 1'bx,
                             exp_d[i], exp_l[i]);
                end
            end
            n_checks++;
            if (hold_err != 0) begin
                n_fail++;
                $display("FAIL bp%0d_hold: got %0d unstable stall cycles, want 0", mode, hold_err);
            end
        end
    endtask

    // Extra start pulses mid-SEND and coincident with DONE must be ignored
    task automatic test_spurious_start(input int restart_k, input string tag);
        fill_fixed();
        build_model();
        collect(0, restart_k, -1);
        n_checks++;
        if (obs_d.size() != exp_d.size() || done_count != 1 || busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ignored: got %0d bytes %0d done busy_after=%b, want %0d bytes 1 done busy_after=0",
                     tag, obs_d.size(), done_count, busy_after, exp_d.size());
        end
        for (int i = 0; i < exp_d.size(); i++) begin
            n_checks++;
            if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL %s_byte[%0d]: got %02h, want %02h", tag,
                         i, (i < obs_d.size()) ? obs_d[i] : 8'hxx, exp_d[i]);
            end
        end
    endtask

    task automatic test_abort_reset();
        fill_fixed();
        build_model();
        collect(0, -1, 5);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, ram_rden, ram_addr, tx_valid, tx_data, tx_last} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got busy=%b done=%b rden=%b addr=%0d valid=%b data=%02h last=%b, want all 0",
                     busy, done, ram_rden, ram_addr, tx_valid, tx_data, tx_last);
        end
        @(posedge clk); #1 rst = 1'b0;
        collect(0, -1, -1);
        n_checks++;
        if (obs_d.size() != exp_d.size()) begin
            n_fail++;
            $display("FAIL replay_count: got %0d bytes, want %0d", obs_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size(); i++) begin
            n_checks++;
            if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL replay_byte[%0d]: got %02h, want %02h",
                         i, (i < obs_d.size()) ? obs_d[i] : 8'hxx, exp_d[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ready_high();
        test_backpressure(1, 1);
        test_backpressure(2, 3);
        test_spurious_start(FIRST_VALID + 3, "start_in_send");
        test_spurious_start(DONE_CYC, "start_at_done");
        test_abort_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
